cpu_trace_monitor: RTL and testbench
====================================

# cpu_trace_monitor

Synthesisable run-control and trace monitor that sits beside the `cpu`/`memory` pair on the CPU bus. It records every memory write and every change of the CPU `out` port into a parametrised trace FIFO, tagged with the current `pc`. It also detects halt (`status`) and enforces a cycle-count timeout. The block moves the halt/timeout/logging functions into hardware, so the same checks work on silicon and on FPGA, widened to arbitrary address/data/PC widths and trace depth.

## Interface
- `ADDR_WIDTH`, 6, CPU memory address width
- `DATA_WIDTH`, 16, memory data and `out` width
- `PC_WIDTH`, 6, program counter width
- `DEPTH`, 16, trace FIFO entries; power of two, ≥2
- `TIMEOUT_CYCLES`, 5000, RUN cycles allowed before timeout; ≥1, < 2^32
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `en` in 1: start monitoring (IDLE→RUN)
- `clr` in 1: synchronous clear of FIFO, counter, flags; returns FSM to IDLE
- `we` in 1: CPU memory write strobe
- `addr` in ADDR_WIDTH: CPU memory address
- `data` in DATA_WIDTH: CPU write data
- `out` in DATA_WIDTH: CPU output port
- `pc` in PC_WIDTH: CPU program counter
- `status` in 1: CPU halt indication
- `trc_rd` in 1: pop the head entry
- `trc_valid` out 1: FIFO not empty; head fields are valid
- `trc_kind` out 2: head kind; bit0 = write, bit1 = out change
- `trc_pc` out PC_WIDTH: head PC
- `trc_addr` out ADDR_WIDTH: head write address
- `trc_data` out DATA_WIDTH: head write data
- `trc_out` out DATA_WIDTH: head `out` value
- `trc_count` out $clog2(DEPTH)+1: occupancy
- `overflow` out 1: sticky; set when an entry was lost
- `halted` out 1: FSM in HALTED
- `timeout` out 1: FSM in TIMEOUT
- `cycle_cnt` out 32: RUN cycles elapsed

## Operation
- FSM states are IDLE, RUN, HALTED and TIMEOUT. Reset puts the FSM in IDLE.
- IDLE→RUN: when `en`=1.
- RUN→HALTED: when `status`=1.
- RUN→TIMEOUT: when `cycle_cnt` == TIMEOUT_CYCLES-1 and `status`=0.
- If halt and timeout conditions occur in the same cycle, `status` wins and the FSM goes to HALTED.
- HALTED and TIMEOUT hold until `clr` or `rst`.
- `clr` overrides every other transition and clears `overflow`, `cycle_cnt` and the FIFO.
- `prev_out` register:
  - Updated to `out` every cycle in every state.
  - Reset value is 0.
  - Out change is defined as `out != prev_out`.
- Event capture happens only in RUN, including the cycle in which `status` is first sampled high.
- Each event cycle pushes exactly one entry: {kind, pc, addr, data, out}.
  - kind = {outchg, we}.
  - Fields not relevant to the kind still carry the sampled bus values.
- FIFO read side is first-word-fall-through. A pop occurs when `trc_rd` && `trc_valid`. `trc_rd` while empty is ignored.
- Full FIFO with a push and no pop: the new entry is dropped and `overflow` is set.
- Full FIFO with simultaneous push and pop: both succeed and `overflow` stays 0.
- `cycle_cnt` behaviour:
  - Increments each RUN cycle.
  - Holds in HALTED and TIMEOUT.
  - Saturates at 2^32-1.

## Timing
- Reset values: `trc_valid`=0, `trc_count`=0, `overflow`=0, `halted`=0, `timeout`=0, `cycle_cnt`=0, and all `trc_*` data fields 0.
- Capture latency is 1 cycle: an event sampled at edge N appears at the FIFO head (if the FIFO was empty) and in `trc_count` after edge N.
- `halted` and `timeout` assert 1 cycle after the triggering sample.
- The first RUN cycle is the cycle after `en` is sampled; `cycle_cnt` reads 1 after that edge.
- Timeout asserts after exactly TIMEOUT_CYCLES RUN cycles.
- Asserting `rst` mid-run empties the FIFO immediately, without waiting for a clock.

## Configuration
- `TRACE_OVERWRITE_EN` defined:
  - A push into a full FIFO drops the oldest entry and accepts the new one; the read pointer advances.
  - `overflow` is still set.
  - `trc_count` stays at DEPTH.
- `TRACE_OVERWRITE_EN` undefined: the newest entry is dropped, as described in Operation.

## Structure
- Package `cpu_trace_pkg` holds:
  - the FSM state enum `mon_state_t`;
  - constants `KIND_WR`=2'b01, `KIND_OUT`=2'b10, `KIND_BOTH`=2'b11;
  - the parametrised entry layout helper, giving the entry width as 2+PC_WIDTH+ADDR_WIDTH+2·DATA_WIDTH.
- Sub-module `trace_fifo` is a generic first-word-fall-through FIFO with parameters WIDTH and DEPTH. It owns the overwrite macro behaviour and the sticky overflow.
- The top level holds the FSM, the `prev_out` register, the cycle counter and entry packing.

## Test plan
- Reset, then `en`; drive `we`=1, `addr`=5, `data`=0x0008, `pc`=3 for one cycle → one entry with kind=01, pc=3, addr=5, data=0x0008; `trc_count`=1.
- `out` 0→0x0010 together with `we`=1 in the same cycle → a single entry with kind=11 and `trc_out`=0x0010.
- `status` raised at RUN cycle 20 → `halted`=1 on the next edge, `cycle_cnt` frozen at 21, later `we` pulses not logged.
- TIMEOUT_CYCLES=50 with `status`=0 → `timeout`=1 after exactly 50 RUN cycles; `cycle_cnt`=50.
- DEPTH=4, 6 write events with no reads:
  - without the macro → entries 1–4 retained, `overflow`=1;
  - with `TRACE_OVERWRITE_EN` → entries 3–6 retained, `overflow`=1.
- Full FIFO with simultaneous push and `trc_rd` → `trc_count` stays 4, `overflow`=0. `rst` pulsed mid-run → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace monitor.
package cpu_trace_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StHalted, StTimeout} mon_state_t;

    localparam logic [1:0] KIND_WR   = 2'b01;
    localparam logic [1:0] KIND_OUT  = 2'b10;
    localparam logic [1:0] KIND_BOTH = 2'b11;

    // Entry layout, MSB first: {kind, pc, addr, data, out}.
    function automatic int unsigned entry_width(input int unsigned pc_w,
                                                input int unsigned addr_w,
                                                input int unsigned data_w);
        return 2 + pc_w + addr_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with sticky overflow.
// TRACE_OVERWRITE_EN: a push into a full FIFO replaces the oldest entry instead of being dropped.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q;
    logic             full, do_pop, drop, wr_en, adv_rd;

    assign full   = (count_q == FULL_CNT);
    assign do_pop = pop && (count_q != '0);
    assign drop   = push && full && !do_pop;

`ifdef TRACE_OVERWRITE_EN
    assign wr_en  = push;
    assign adv_rd = do_pop || drop;
`else
    assign wr_en  = push && !drop;
    assign adv_rd = do_pop;
`endif

    always_comb begin
        count_d = count_q;
        if (wr_en && !adv_rd) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_en && adv_rd) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (adv_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem_q[wr_ptr_q] <= wdata;
    end

    assign valid    = (count_q != '0);
    assign rdata    = valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/cpu_trace_monitor.sv
// Run-control and trace monitor: halt/timeout FSM, RUN cycle counter, write/out-change trace.
// Trace FIFO full behaviour selectable via TRACE_OVERWRITE_EN (see trace_fifo).
module cpu_trace_monitor
    import cpu_trace_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned PC_WIDTH       = 6,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic [DATA_WIDTH-1:0]     out,
    input  logic [PC_WIDTH-1:0]       pc,
    input  logic                      status,
    input  logic                      trc_rd,
    output logic                      trc_valid,
    output logic [1:0]                trc_kind,
    output logic [PC_WIDTH-1:0]       trc_pc,
    output logic [ADDR_WIDTH-1:0]     trc_addr,
    output logic [DATA_WIDTH-1:0]     trc_data,
    output logic [DATA_WIDTH-1:0]     trc_out,
    output logic [$clog2(DEPTH):0]    trc_count,
    output logic                      overflow,
    output logic                      halted,
    output logic                      timeout,
    output logic [31:0]               cycle_cnt
);

    localparam int unsigned EW = entry_width(PC_WIDTH, ADDR_WIDTH, DATA_WIDTH);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    mon_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] prev_out_q;
    logic [31:0]           cycle_cnt_q;
    logic [1:0]            kind;
    logic                  capture;
    logic [EW-1:0]         push_entry, head_entry;

    assign kind       = {(out != prev_out_q), we};
    assign capture    = (state_q == StRun) && (kind != 2'b00);
    assign push_entry = {kind, pc, addr, data, out};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (en) state_d = StRun;
            StRun: begin
                // Halt takes priority over a coincident timeout.
                if (status) state_d = StHalted;
                else if (cycle_cnt_q == TO_LAST) state_d = StTimeout;
            end
            StHalted:  state_d = StHalted;
            StTimeout: state_d = StTimeout;
        endcase
        if (clr) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            prev_out_q  <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_out_q <= out;
            if (clr) begin
                cycle_cnt_q <= '0;
            end else if (state_q == StRun && cycle_cnt_q != '1) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .push     (capture),
        .wdata    (push_entry),
        .pop      (trc_rd),
        .rdata    (head_entry),
        .valid    (trc_valid),
        .count    (trc_count),
        .overflow (overflow)
    );

    assign {trc_kind, trc_pc, trc_addr, trc_data, trc_out} = head_entry;
    assign halted    = (state_q == StHalted);
    assign timeout   = (state_q == StTimeout);
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor (DEPTH=4, TIMEOUT_CYCLES=50).
module tb_cpu_trace_monitor;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 6;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO = 50;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, en, clr, we, status, trc_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data, out;
    logic [PW-1:0] pc;
    logic          trc_valid, overflow, halted, timeout;
    logic [1:0]    trc_kind;
    logic [PW-1:0] trc_pc;
    logic [AW-1:0] trc_addr;
    logic [DW-1:0] trc_data, trc_out;
    logic [CW-1:0] trc_count;
    logic [31:0]   cycle_cnt;

    int checks = 0;
    int errors = 0;

    cpu_trace_monitor #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .PC_WIDTH       (PW),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .we        (we),
        .addr      (addr),
        .data      (data),
        .out       (out),
        .pc        (pc),
        .status    (status),
        .trc_rd    (trc_rd),
        .trc_valid (trc_valid),
        .trc_kind  (trc_kind),
        .trc_pc    (trc_pc),
        .trc_addr  (trc_addr),
        .trc_data  (trc_data),
        .trc_out   (trc_out),
        .trc_count (trc_count),
        .overflow  (overflow),
        .halted    (halted),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic write_ev(input int v);
        we = 1'b1;
        addr = AW'(v);
        data = DW'(v);
        tick();
        we = 1'b0;
    endtask

    task automatic pop_one();
        trc_rd = 1'b1;
        tick();
        trc_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 0; clr = 0; we = 0; status = 0; trc_rd = 0;
        addr = '0; data = '0; out = '0; pc = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", trc_valid); end
        checks++; if (trc_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", trc_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        checks++; if (halted !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL rst_flags got=%b%b exp=00", halted, timeout); end
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cycle_cnt); end
        checks++; if ({trc_kind, trc_pc, trc_addr, trc_data, trc_out} !== '0) begin
            errors++; $display("FAIL rst_fields got=%h exp=0", {trc_kind, trc_pc, trc_addr, trc_data, trc_out}); end
    endtask

    task automatic test_write();
        en = 1'b1;
        tick();
        en = 1'b0;
        we = 1'b1; addr = 6'd5; data = 16'h0008; pc = 6'd3;
        tick();
        we = 1'b0;
        checks++; if (trc_count !== 3'd1) begin errors++; $display("FAIL wr_count got=%0d exp=1", trc_count); end
        checks++; if (trc_valid !== 1'b1) begin errors++; $display("FAIL wr_valid got=%b exp=1", trc_valid); end
        checks++; if (trc_kind !== 2'b01) begin errors++; $display("FAIL wr_kind got=%b exp=01", trc_kind); end
        checks++; if (trc_pc !== 6'd3) begin errors++; $display("FAIL wr_pc got=%0d exp=3", trc_pc); end
        checks++; if (trc_addr !== 6'd5) begin errors++; $display("FAIL wr_addr got=%0d exp=5", trc_addr); end
        checks++; if (trc_data !== 16'h0008) begin errors++; $display("FAIL wr_data got=%h exp=0008", trc_data); end
        checks++; if (trc_out !== 16'h0000) begin errors++; $display("FAIL wr_out got=%h exp=0000", trc_out); end
        checks++; if (cycle_cnt !== 32'd1) begin errors++; $display("FAIL wr_cnt got=%0d exp=1", cycle_cnt); end
        pop_one();
        checks++; if (trc_valid !== 1'b0 || trc_count !== 3'd0) begin
            errors++; $display("FAIL wr_pop got=%b/%0d exp=0/0", trc_valid, trc_count); end
        pop_one();
        checks++; if (trc_count !== 3'd0) begin errors++; $display("FAIL empty_rd got=%0d exp=0", trc_count); end
    endtask

    task automatic test_out_both();
        out = 16'h0010; we = 1'b1; addr = 6'd7; data = 16'h0022; pc = 6'd4;
        tick();
        we = 1'b0;
        checks++; if (trc_count !== 3'd1) begin errors++; $display("FAIL both_count got=%0d exp=1", trc_count); end
        checks++; if (trc_kind !== 2'b11) begin errors++; $display("FAIL both_kind got=%b exp=11", trc_kind); end
        checks++; if (trc_out !== 16'h0010) begin errors++; $display("FAIL both_out got=%h exp=0010", trc_out); end
        checks++; if (trc_data !== 16'h0022 || trc_addr !== 6'd7) begin
            errors++; $display("FAIL both_wr got=%h/%0d exp=0022/7", trc_data, trc_addr); end
        tick();
        checks++; if (trc_count !== 3'd1) begin errors++; $display("FAIL out_steady got=%0d exp=1", trc_count); end
        pop_one();
    endtask

    task automatic test_halt();
        start_run();
        repeat (20) tick();
        checks++; if (cycle_cnt !== 32'd20) begin errors++; $display("FAIL halt_pre got=%0d exp=20", cycle_cnt); end
        status = 1'b1;
        tick();
        status = 1'b0;
        checks++; if (halted !== 1'b1 || timeout !== 1'b0) begin
            errors++; $display("FAIL halt_flag got=%b%b exp=10", halted, timeout); end
        checks++; if (cycle_cnt !== 32'd21) begin errors++; $display("FAIL halt_cnt got=%0d exp=21", cycle_cnt); end
        write_ev(9);
        tick();
        checks++; if (trc_count !== 3'd0) begin errors++; $display("FAIL halt_nolog got=%0d exp=0", trc_count); end
        checks++; if (cycle_cnt !== 32'd21 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_hold got=%0d/%b exp=21/1", cycle_cnt, halted); end
    endtask

    task automatic test_timeout();
        start_run();
        repeat (TO - 1) tick();
        checks++; if (timeout !== 1'b0 || cycle_cnt !== 32'd49) begin
            errors++; $display("FAIL to_pre got=%b/%0d exp=0/49", timeout, cycle_cnt); end
        tick();
        checks++; if (timeout !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL to_flag got=%b%b exp=01", timeout, halted); end
        checks++; if (cycle_cnt !== 32'd50) begin errors++; $display("FAIL to_cnt got=%0d exp=50", cycle_cnt); end
        repeat (3) tick();
        checks++; if (cycle_cnt !== 32'd50 || timeout !== 1'b1) begin
            errors++; $display("FAIL to_hold got=%0d/%b exp=50/1", cycle_cnt, timeout); end
    endtask

    task automatic test_overflow();
        int first;
`ifdef TRACE_OVERWRITE_EN
        first = 3;
`else
        first = 1;
`endif
        start_run();
        for (int i = 1; i <= 6; i++) write_ev(i);
        checks++; if (trc_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", trc_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (trc_data !== DW'(first + k)) begin
                errors++; $display("FAIL ovf_entry%0d got=%0d exp=%0d", k, trc_data, first + k); end
            pop_one();
        end
        checks++; if (trc_count !== 3'd0) begin errors++; $display("FAIL ovf_drain got=%0d exp=0", trc_count); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_back_to_back();
        start_run();
        for (int i = 1; i <= 4; i++) write_ev(i);
        checks++; if (trc_count !== 3'd4 || overflow !== 1'b0) begin
            errors++; $display("FAIL b2b_full got=%0d/%b exp=4/0", trc_count, overflow); end
        we = 1'b1; addr = 6'd5; data = 16'd5; trc_rd = 1'b1;
        tick();
        we = 1'b0; trc_rd = 1'b0;
        checks++; if (trc_count !== 3'd4 || overflow !== 1'b0) begin
            errors++; $display("FAIL b2b_pushpop got=%0d/%b exp=4/0", trc_count, overflow); end
        for (int k = 2; k <= 5; k++) begin
            checks++; if (trc_data !== DW'(k)) begin
                errors++; $display("FAIL b2b_entry got=%0d exp=%0d", trc_data, k); end
            pop_one();
        end
    endtask

    task automatic test_rst_midrun();
        start_run();
        write_ev(1);
        write_ev(2);
        checks++; if (trc_count !== 3'd2) begin errors++; $display("FAIL mid_pre got=%0d exp=2", trc_count); end
        rst = 1'b1;
        #2;
        checks++; if (trc_valid !== 1'b0 || trc_count !== 3'd0) begin
            errors++; $display("FAIL mid_fifo got=%b/%0d exp=0/0", trc_valid, trc_count); end
        checks++; if (cycle_cnt !== 32'd0 || halted !== 1'b0 || timeout !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_state got=%0d/%b%b%b exp=0/000", cycle_cnt, halted, timeout, overflow); end
        checks++; if (trc_data !== 16'h0000 || trc_kind !== 2'b00) begin
            errors++; $display("FAIL mid_fields got=%h/%b exp=0000/00", trc_data, trc_kind); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_out_both();
        test_halt();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_rst_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
